// File: rtl/maxpool_2x2_stream_if.sv
// maxpool_2x2_stream_if
// Stream bundle between a pixel producer, the 2x2 max-pool block and the
// pooled-pixel consumer.
//   in_valid / in_ready / in_data    : input pixel stream, raster order
//   out_valid / out_ready / out_data : pooled pixel stream
//   frame_done                       : one-cycle end-of-frame pulse from the pool block
// Modports:
//   master : the environment (drives inputs, consumes outputs)
//   slave  : the pooling block
interface maxpool_2x2_stream_if #(
    parameter int IP_DATA_WIDTH = 8
);
    logic                            in_valid;
    logic                            in_ready;
    logic signed [IP_DATA_WIDTH-1:0] in_data;
    logic                            out_valid;
    logic                            out_ready;
    logic signed [IP_DATA_WIDTH-1:0] out_data;
    logic                            frame_done;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, frame_done
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, frame_done
    );
endinterface

// File: rtl/maxpool_2x2_stream.sv
// maxpool_2x2_stream
// Streaming 2x2 / stride-2 signed max pooling over raster-order frames of
// IMG_W x IMG_H pixels. Even rows fold horizontal pixel pairs into a half-
// width line buffer; odd rows fold their pairs with the buffered value and
// emit one pooled pixel per pair, with one cycle of latency.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : maxpool_2x2_stream_if.slave (input stream, output stream, frame_done)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// EVEN_ROW | top row of a 2x2 window: pair max goes to the line buffer
// ODD_ROW  | bottom row: pair max combined with line buffer, emitted
module maxpool_2x2_stream #(
    parameter int IP_DATA_WIDTH = 8,
    parameter int IMG_W         = 8,
    parameter int IMG_H         = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    maxpool_2x2_stream_if.slave    bus
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;

    typedef enum logic {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } state_t;

    typedef logic signed [IP_DATA_WIDTH-1:0] pix_t;

    state_t         state_q;
    logic [CW-1:0]  col_q;
    logic [RW-1:0]  row_q;
    pix_t           h_q;
    pix_t           out_data_q;
    logic           out_valid_q;
    logic           frame_done_q;
    pix_t           lbuf [IMG_W/2];

    logic           xfer;
    logic [LW-1:0]  lidx;
    logic           col_last;
    logic           row_last;
    pix_t           pair_max;

    function automatic pix_t smax(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    // A held result the consumer is not taking blocks new input, so a new
    // result can never overwrite an unconsumed one.
    assign bus.in_ready  = !(out_valid_q && !bus.out_ready);
    assign xfer          = bus.in_valid && bus.in_ready;

    assign lidx          = LW'(col_q >> 1);
    assign col_last      = (col_q == CW'(IMG_W - 1));
    assign row_last      = (row_q == RW'(IMG_H - 1));
    assign pair_max      = smax(h_q, bus.in_data);

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.frame_done = frame_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EVEN_ROW;
            col_q        <= '0;
            row_q        <= '0;
            h_q          <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (xfer) begin
                if (!col_q[0]) begin
                    h_q <= bus.in_data;
                end else if (state_q == ODD_ROW) begin
                    // A load on the same edge as a consume wins, keeping out_valid high.
                    out_data_q  <= smax(pair_max, lbuf[lidx]);
                    out_valid_q <= 1'b1;
                end

                if (col_last) begin
                    col_q   <= '0;
                    state_q <= (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
                    if (row_last) begin
                        row_q        <= '0;
                        frame_done_q <= 1'b1;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    // Line buffer is left out of reset: every entry is written on an even
    // row before the following odd row reads it.
    always_ff @(posedge clk) begin
        if (xfer && col_q[0] && (state_q == EVEN_ROW)) begin
            lbuf[lidx] <= pair_max;
        end
    end
endmodule
